kmeans_apb_slave: RTL

Parametrised APB3 slave front-end for the Kmeans accelerator. It generalises the plain APB pin bundle with a decoded register file, a windowed point/centroid RAM port, configurable wait states, error response, start/busy/done control, and a sticky, maskable interrupt. It sits between the testbench/host APB master and the Kmeans core plus its RAM.

---
 rtl/kmeans_apb_slave.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/kmeans_apb_slave.sv
// rtl/kmeans_apb_slave.sv - APB3 slave front-end for the Kmeans accelerator
module kmeans_apb_slave #(
  parameter  int ADDR_WIDTH  = 9,
  parameter  int DATA_WIDTH  = 91,
  parameter  int REG_AMOUNT  = 8,
  parameter  int RAM_DEPTH   = 256,
  parameter  int RAM_LATENCY = 1,
  parameter  int WAIT_STATES = 0,
  localparam int RAM_AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  psel,
  input  logic                                  penable,
  input  logic                                  pwrite,
  input  logic [ADDR_WIDTH-1:0]                 paddr,
  input  logic [DATA_WIDTH-1:0]                 pwdata,
  output logic [DATA_WIDTH-1:0]                 prdata,
  output logic                                  pready,
  output logic                                  pslverr,
  output logic                                  interrupt,
  output logic                                  start,
  input  logic                                  core_done,
  output logic [(REG_AMOUNT-2)*DATA_WIDTH-1:0]  cfg_regs,
  output logic                                  ram_en,
  output logic                                  ram_we,
  output logic [RAM_AW-1:0]                     ram_addr,
  output logic [DATA_WIDTH-1:0]                 ram_wdata,
  input  logic [DATA_WIDTH-1:0]                 ram_rdata
);

  // One counter serves both the write/register wait states and the RAM read latency.
  localparam int CNT_MAX = (WAIT_STATES > RAM_LATENCY) ? WAIT_STATES : RAM_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RIDX_W  = $clog2(REG_AMOUNT);

  localparam logic [ADDR_WIDTH:0] LP_REG_END = (ADDR_WIDTH+1)'(REG_AMOUNT);
  localparam logic [ADDR_WIDTH:0] LP_RAM_END = (ADDR_WIDTH+1)'(REG_AMOUNT + RAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transfer context captured in the SETUP cycle
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [RIDX_W-1:0]     r_ridx;
  logic [RAM_AW-1:0]     r_ram_addr;
  logic                  r_is_ram;
  logic                  r_err;
  logic                  r_first;
  logic [CNT_W-1:0]      r_cnt;

  // Register file state
  logic                  r_irq_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;
  logic                  r_start;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_cfg [2:REG_AMOUNT-1];

  logic                  w_setup;
  logic                  w_in_reg;
  logic                  w_in_ram;
  logic                  w_bad;
  logic                  w_commit;
  logic                  w_wr_reg;
  logic                  w_ctrl_wr;
  logic                  w_stat_wr;
  logic                  w_start_req;
  logic                  w_start_ok;
  logic [DATA_WIDTH-1:0] w_reg_rdata;

  assign w_setup  = psel & ~penable;
  assign w_in_reg = {1'b0, paddr} < LP_REG_END;
  assign w_in_ram = ~w_in_reg & ({1'b0, paddr} < LP_RAM_END);
  // Out-of-range addresses and RAM traffic while the core owns the RAM are refused.
  assign w_bad    = ~(w_in_reg | w_in_ram) | (w_in_ram & r_busy);

  assign w_wr_reg    = w_commit & r_write & ~r_is_ram & ~r_err;
  assign w_ctrl_wr   = w_wr_reg & (r_ridx == RIDX_W'(0));
  assign w_stat_wr   = w_wr_reg & (r_ridx == RIDX_W'(1));
  assign w_start_req = w_ctrl_wr & r_wdata[0];
  assign w_start_ok  = w_start_req & ~r_busy;

  assign start     = r_start;
  assign interrupt = r_irq;

  for (genvar g = 2; g < REG_AMOUNT; g++) begin : g_cfg
    assign cfg_regs[(g-2)*DATA_WIDTH +: DATA_WIDTH] = r_cfg[g];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture transfer context at SETUP and run the wait/latency counter during ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_ridx     <= '0;
      r_ram_addr <= '0;
      r_is_ram   <= 1'b0;
      r_err      <= 1'b0;
      r_first    <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == S_IDLE && w_setup) begin
      r_write    <= pwrite;
      r_wdata    <= pwdata;
      r_ridx     <= RIDX_W'(paddr);
      r_ram_addr <= RAM_AW'(paddr - ADDR_WIDTH'(REG_AMOUNT));
      r_is_ram   <= w_in_ram;
      r_err      <= w_bad;
      r_first    <= 1'b1;
      if (w_bad) begin
        r_cnt <= '0;
      end else if (w_in_ram && !pwrite) begin
        r_cnt <= CNT_W'(RAM_LATENCY);
      end else begin
        r_cnt <= CNT_W'(WAIT_STATES);
      end
    end else if (r_state == S_ACCESS) begin
      r_first <= 1'b0;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Next state and APB/RAM outputs; RAM address/data are only driven while ram_en is high
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (r_first && r_is_ram && !r_write && !r_err) begin
            ram_en   = 1'b1;
            ram_addr = r_ram_addr;
          end
          if (r_cnt == '0) begin
            pready  = 1'b1;
            pslverr = r_err;
            if (!r_write && !r_err) begin
              prdata = r_is_ram ? ram_rdata : w_reg_rdata;
            end
            if (penable) begin
              w_commit    = 1'b1;
              w_state_nxt = S_DONE;
              if (r_is_ram && r_write && !r_err) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_ram_addr;
                ram_wdata = r_wdata;
              end
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Register read mux; unused bits read as zero
  always_comb begin
    w_reg_rdata = '0;
    if (r_ridx == RIDX_W'(0)) begin
      w_reg_rdata[1] = r_irq_en;
    end else if (r_ridx == RIDX_W'(1)) begin
      w_reg_rdata[0] = r_busy;
      w_reg_rdata[1] = r_done;
      w_reg_rdata[2] = r_overrun;
    end else begin
      for (int i = 2; i < REG_AMOUNT; i++) begin
        if (r_ridx == RIDX_W'(i)) begin
          w_reg_rdata = r_cfg[i];
        end
      end
    end
  end

  // CTRL/STATUS: start handshake, sticky flags (set beats W1C) and registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_start   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_start <= w_start_ok;
      if (w_ctrl_wr) begin
        r_irq_en <= r_wdata[1];
      end
      if (w_start_ok) begin
        r_busy <= 1'b1;
      end else if (core_done) begin
        r_busy <= 1'b0;
      end
      r_done    <= core_done | (r_done & ~(w_stat_wr & r_wdata[1]));
      r_overrun <= (w_start_req & r_busy) | (r_overrun & ~(w_stat_wr & r_wdata[2]));
      r_irq     <= r_irq_en & (r_done | r_overrun);
    end
  end

  // Plain RW configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 2; i < REG_AMOUNT; i++) begin
        r_cfg[i] <= '0;
      end
    end else if (w_wr_reg) begin
      for (int i = 2; i < REG_AMOUNT; i++) begin
        if (r_ridx == RIDX_W'(i)) begin
          r_cfg[i] <= r_wdata;
        end
      end
    end
  end

endmodule
